// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared types and constants for the two-requester round-robin mux arbiter
//
// Purpose: arbiter state encoding and mux select constants used by
//          mux2_rr_arbiter and mux2_datapath.
// Ports:   none (package).
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

endpackage

// File: rtl/mux2_datapath.sv
// rtl/mux2_datapath.sv - combinational 2:1 bus mux shared by the two requesters
//
// Purpose: steer one of two requester buses onto the consumer bus.
// Ports:
//   d0   in  [WIDTH-1:0]  requester 0 data
//   d1   in  [WIDTH-1:0]  requester 1 data
//   sel  in  1            SEL_D0 picks d0, SEL_D1 picks d1
//   dout out [WIDTH-1:0]  selected data
module mux2_datapath
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] dout
);

  assign dout = (sel == SEL_D1) ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin req/gnt arbiter driving a shared 2:1 data mux
//
// Purpose: grant one of two requesters at a time, alternating on ties, and
//          present the owner's data with a valid flag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req0, req1        requests, held high for the whole transfer
//   d0, d1            requester data buses
//   gnt0, gnt1        registered grants, never both high
//   sel               registered mux select (0 = d0, 1 = d1), held in IDLE
//   dout              combinational mux output
//   dout_vld          owner's grant and request both high
//   busy              registered, high while a grant is active
// Build option: define MUX2_ARB_TIMEOUT_EN to force a grant hand-over after
//   MAX_HOLD cycles when the other side is waiting.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             busy
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       busy_q, busy_d;
  logic       timeout_hit;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Clears on any state change; counts up while a grant is held.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if (state_q != IDLE && hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign timeout_hit = (hold_cnt_q == HOLD_MAX);
`else
  // Without the timeout a grant is only released by its request; MAX_HOLD
  // has no effect here.
  assign timeout_hit = 1'b0 & (MAX_HOLD < 2);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    unique case (state_q)
      // On a tie the requester that did not own last wins.
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      // A dropped request hands over directly when the other side waits.
      OWN0: begin
        if (!req0) begin
          state_d = req1 ? OWN1 : IDLE;
        end else if (timeout_hit && req1) begin
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_d = req0 ? OWN0 : IDLE;
        end else if (timeout_hit && req0) begin
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == OWN0 && state_q != OWN0) begin
      last_d = 1'b0;
      sel_d  = SEL_D0;
    end else if (state_d == OWN1 && state_q != OWN1) begin
      last_d = 1'b1;
      sel_d  = SEL_D1;
    end

    gnt0_d = (state_d == OWN0);
    gnt1_d = (state_d == OWN1);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= SEL_D0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
    end
  end

  mux2_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .d0  (d0),
    .d1  (d1),
    .sel (sel_q),
    .dout(dout)
  );

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign dout_vld = (gnt0_q & req0) | (gnt1_q & req1);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - self-checking bench for mux2_rr_arbiter against an owner/last reference model
module tb_mux2_rr_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
`ifdef MUX2_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] d0, d1;
  logic             gnt0, gnt1, sel, dout_vld, busy;
  logic [WIDTH-1:0] dout;

  int total = 0;
  int bad   = 0;

  // Reference model: owner is -1 (nobody), 0 or 1.
  int m_owner = -1;
  int m_last  = 1;
  int m_sel   = 0;
  int m_hold  = 0;

  mux2_rr_arbiter #(
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .d0      (d0),
    .d1      (d1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .dout    (dout),
    .dout_vld(dout_vld),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_tick();
    int r[2];
    int nxt;
    int o;
    r[0] = int'(req0);
    r[1] = int'(req1);
    if (rst) begin
      m_owner = -1;
      m_last  = 1;
      m_sel   = 0;
      m_hold  = 0;
      return;
    end
    nxt = m_owner;
    if (m_owner < 0) begin
      if (r[0] != 0 && r[1] != 0) nxt = 1 - m_last;
      else if (r[0] != 0)         nxt = 0;
      else if (r[1] != 0)         nxt = 1;
    end else begin
      o = 1 - m_owner;
      if (r[m_owner] == 0)                                       nxt = (r[o] != 0) ? o : -1;
      else if (TIMEOUT && m_hold == MAX_HOLD - 1 && r[o] != 0)   nxt = o;
    end
    if (nxt != m_owner) begin
      m_hold = 0;
      if (nxt >= 0) begin
        m_last = nxt;
        m_sel  = nxt;
      end
    end else if (m_owner >= 0 && m_hold < MAX_HOLD - 1) begin
      m_hold++;
    end
    m_owner = nxt;
  endtask

  task automatic check_outputs();
    logic [WIDTH-1:0] exp_dout;
    logic             exp_vld;
    exp_dout = (m_sel == 1) ? d1 : d0;
    exp_vld  = (m_owner == 0 && req0) || (m_owner == 1 && req1);
    check("gnt0",     32'(gnt0),        32'(m_owner == 0));
    check("gnt1",     32'(gnt1),        32'(m_owner == 1));
    check("busy",     32'(busy),        32'(m_owner >= 0));
    check("sel",      32'(sel),         32'(m_sel));
    check("dout",     32'(dout),        32'(exp_dout));
    check("dout_vld", 32'(dout_vld),    32'(exp_vld));
    check("onehot",   32'(gnt0 & gnt1), 32'(0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst  = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    d0   = 8'h3C;
    d1   = 8'hC3;

    // Reset with both requesting: nothing granted.
    repeat (2) cycle();
    check("rst_gnt0", 32'(gnt0), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;

    // Tie after reset: requester 0 first, then direct hand-over to 1.
    cycle();
    check("tie_first_gnt0", 32'(gnt0), 32'(1));
    req0 = 1'b0;
    cycle();
    check("tie_handover_gnt1", 32'(gnt1), 32'(1));
    check("tie_handover_busy", 32'(busy), 32'(1));
    req1 = 1'b0;
    cycle();
    check("tie_idle_busy", 32'(busy), 32'(0));
    req0 = 1'b1;
    req1 = 1'b1;
    cycle();
    check("tie_again_gnt0", 32'(gnt0), 32'(1));

    // Single requester.
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) cycle();
    req1 = 1'b1;
    d1   = 8'hA5;
    cycle();
    check("single_gnt1", 32'(gnt1), 32'(1));
    check("single_dout", 32'(dout), 32'(8'hA5));
    check("single_vld",  32'(dout_vld), 32'(1));
    repeat (3) cycle();
    req1 = 1'b0;
    cycle();
    check("single_drop_gnt1", 32'(gnt1), 32'(0));
    check("single_drop_busy", 32'(busy), 32'(0));
    check("single_sel_held",  32'(sel),  32'(1));

    // Back-to-back alternation by pulsing the owner's request.
    req0 = 1'b1;
    req1 = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      logic prev_gnt0;
      prev_gnt0 = gnt0;
      if (gnt0) req0 = 1'b0;
      else      req1 = 1'b0;
      cycle();
      check("alt_switch", 32'(gnt0), 32'(!prev_gnt0));
      req0 = 1'b1;
      req1 = 1'b1;
      cycle();
    end

    // Mid-transfer reset while requester 1 owns.
    req0 = 1'b0;
    req1 = 1'b0;
    cycle();
    req1 = 1'b1;
    cycle();
    check("mid_owner1", 32'(gnt1), 32'(1));
    rst = 1'b1;
    cycle();
    check("mid_rst_gnt1", 32'(gnt1), 32'(0));
    rst  = 1'b0;
    req0 = 1'b1;
    cycle();
    check("mid_after_gnt0", 32'(gnt0), 32'(1));

    // Long hold with the other side waiting.
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) cycle();
    req0 = 1'b1;
    cycle();
    req1 = 1'b1;
`ifdef MUX2_ARB_TIMEOUT_EN
    repeat (3) begin
      cycle();
      check("to_hold_gnt0", 32'(gnt0), 32'(1));
    end
    cycle();
    check("to_pre_gnt0", 32'(gnt0), 32'(0));
    check("to_pre_gnt1", 32'(gnt1), 32'(1));
`else
    repeat (24) begin
      cycle();
      check("hold_gnt0", 32'(gnt0), 32'(1));
    end
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (req0) req0 = ($urandom_range(5) != 0);
      else      req0 = ($urandom_range(2) == 0);
      if (req1) req1 = ($urandom_range(5) != 0);
      else      req1 = ($urandom_range(2) == 0);
      d0  = WIDTH'($urandom);
      d1  = WIDTH'($urandom);
      rst = ($urandom_range(49) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
